// File: rtl/maze_map.sv
// Wall/visited cell store for the maze walker: 1-cycle registered lookups, visited marking,
// row-streamed wall load and visited clear. Define MAZE_MAP_VISIT_CNT_EN to add the visitCnt output.
module maze_map #(
  parameter int COORD_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ldStart,
  input  logic                   ldValid,
  input  logic [(1<<COORD_W)-1:0] ldData,
  output logic                   ldReady,
  output logic                   ldDone,
  input  logic                   clrVisit,
  input  logic                   rdReq,
  input  logic [2*COORD_W-1:0]   rdLoc,
  output logic                   rdValid,
  output logic                   rdWall,
  output logic                   rdVisited,
  input  logic                   mark,
  input  logic [2*COORD_W-1:0]   markLoc,
  output logic                   busy
`ifdef MAZE_MAP_VISIT_CNT_EN
  ,
  output logic [2*COORD_W:0]     visitCnt
`endif
);

  localparam int N = 1 << COORD_W;
  localparam logic [COORD_W-1:0] LAST_ROW = '1;
`ifdef MAZE_MAP_VISIT_CNT_EN
  localparam logic [2*COORD_W:0] CNT_MAX = {1'b1, {(2*COORD_W){1'b0}}};
`endif

  typedef enum logic [1:0] {READY, LOAD, CLEAR} state_t;

  state_t                     state;
  logic [COORD_W-1:0]         rowCnt;
  // Indexed [x][y]; a row is every x at one y.
  logic [N-1:0][N-1:0]        wallMap;
  logic [N-1:0][N-1:0]        visitMap;

  logic [COORD_W-1:0] rdX, rdY, mkX, mkY;
  assign rdX = rdLoc[2*COORD_W-1:COORD_W];
  assign rdY = rdLoc[COORD_W-1:0];
  assign mkX = markLoc[2*COORD_W-1:COORD_W];
  assign mkY = markLoc[COORD_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= READY;
      rowCnt    <= '0;
      wallMap   <= '0;
      visitMap  <= '0;
      ldReady   <= 1'b0;
      ldDone    <= 1'b0;
      rdValid   <= 1'b0;
      rdWall    <= 1'b0;
      rdVisited <= 1'b0;
      busy      <= 1'b0;
`ifdef MAZE_MAP_VISIT_CNT_EN
      visitCnt  <= '0;
`endif
    end else begin
      ldDone  <= 1'b0;
      rdValid <= 1'b0;
      // Read sees pre-edge contents, so a same-cycle mark is not visible yet.
      if (rdReq && !busy) begin
        rdValid   <= 1'b1;
        rdWall    <= wallMap[rdX][rdY];
        rdVisited <= visitMap[rdX][rdY];
      end

      case (state)
        READY: begin
          if (mark) begin
            visitMap[mkX][mkY] <= 1'b1;
`ifdef MAZE_MAP_VISIT_CNT_EN
            if (!visitMap[mkX][mkY] && visitCnt != CNT_MAX)
              visitCnt <= visitCnt + 1'b1;
`endif
          end
          if (ldStart) begin
            state   <= LOAD;
            rowCnt  <= '0;
            busy    <= 1'b1;
            ldReady <= 1'b1;
          end else if (clrVisit) begin
            state  <= CLEAR;
            rowCnt <= '0;
            busy   <= 1'b1;
          end
        end

        LOAD: begin
          if (ldValid) begin
            for (int x = 0; x < N; x++) begin
              wallMap[x][rowCnt]  <= ldData[x];
              visitMap[x][rowCnt] <= 1'b0;
            end
            rowCnt <= rowCnt + 1'b1;
            if (rowCnt == LAST_ROW) begin
              state   <= READY;
              busy    <= 1'b0;
              ldReady <= 1'b0;
              ldDone  <= 1'b1;
`ifdef MAZE_MAP_VISIT_CNT_EN
              visitCnt <= '0;
`endif
            end
          end
        end

        CLEAR: begin
          for (int x = 0; x < N; x++)
            visitMap[x][rowCnt] <= 1'b0;
          rowCnt <= rowCnt + 1'b1;
          if (rowCnt == LAST_ROW) begin
            state <= READY;
            busy  <= 1'b0;
`ifdef MAZE_MAP_VISIT_CNT_EN
            visitCnt <= '0;
`endif
          end
        end

        default: begin
          state   <= READY;
          busy    <= 1'b0;
          ldReady <= 1'b0;
        end
      endcase
    end
  end

endmodule
